aes_block_loader: RTL and testbench

- Upstream feeder for the combinational AES-128 encrypt datapath.
- Accepts a byte stream with valid/ready handshake and packs it into 128-bit plaintext blocks.
- Applies PKCS#7 padding to the end of each message.
- Presents each block, together with the message key, through a valid/ready output to the encrypt stage.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_pkcs7_pad.sv | 26 ++
 rtl/aes_block_loader.sv | 115 +++++++++++
 tb/tb_aes_block_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and state type for the AES block loader
package aes_pkg;
    localparam int BLOCK_W         = 128;
    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam logic [BYTE_W-1:0] PKCS_FULL_PAD = 8'h10;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/aes_pkcs7_pad.sv
// rtl/aes_pkcs7_pad.sv - fills bytes k..15 of a block with PKCS#7 pad or zeros
module aes_pkcs7_pad
    import aes_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic [BLOCK_W-1:0] blk_in,
    input  logic [4:0]         k,
    output logic [BLOCK_W-1:0] blk_out
);

    logic [BYTE_W-1:0] fill_byte;

    assign fill_byte = PAD_EN ? {3'b000, 5'd16 - k} : 8'h00;

    // k == 16 leaves the block untouched since no index reaches it
    always_comb begin
        blk_out = blk_in;
        for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
            if (5'(i) >= k) begin
                blk_out[BLOCK_W-1-BYTE_W*i -: BYTE_W] = fill_byte;
            end
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - packs a byte stream into padded 128-bit blocks for AES encrypt
module aes_block_loader
    import aes_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic [BLOCK_W-1:0]  key,
    output logic [BLOCK_W-1:0]  m_block,
    output logic [BLOCK_W-1:0]  m_key,
    output logic                m_valid,
    output logic                m_last,
    input  logic                m_ready,
    output logic                busy
);

    state_t state, state_next;

    logic [3:0]         cnt;
    logic               first;
    logic               pend_extra;
    logic               ready_en;
    logic               xfer;
    logic               fin;
    logic               hs;
    logic [4:0]         k;
    logic [BLOCK_W-1:0] merged;
    logic [BLOCK_W-1:0] padded;

    // ready_en holds s_ready low for the first cycle after reset release
    assign s_ready = ready_en && (state == FILL);
    assign m_valid = (state == HOLD);
    assign xfer    = s_valid && s_ready;
    assign fin     = xfer && ((cnt == 4'd15) || s_last);
    assign hs      = m_valid && m_ready;
    assign k       = {1'b0, cnt} + 5'd1;

    always_comb begin
        merged = m_block;
        merged[BLOCK_W-1-BYTE_W*int'(cnt) -: BYTE_W] = s_data;
    end

    aes_pkcs7_pad #(
        .PAD_EN(PAD_EN)
    ) u_pad (
        .blk_in (merged),
        .k      (k),
        .blk_out(padded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: if (fin) state_next = HOLD;
            HOLD: if (hs && !pend_extra) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_block    <= '0;
            m_key      <= '0;
            m_last     <= 1'b0;
            busy       <= 1'b0;
            cnt        <= 4'd0;
            first      <= 1'b1;
            pend_extra <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (xfer) begin
                if (first) begin
                    m_key <= key;
                    busy  <= 1'b1;
                    first <= 1'b0;
                end
                if (fin) begin
                    m_block <= padded;
                    cnt     <= 4'd0;
                    // a full final block under PKCS#7 still owes one all-0x10 block
                    m_last     <= s_last && !((cnt == 4'd15) && PAD_EN);
                    pend_extra <= s_last && (cnt == 4'd15) && PAD_EN;
                end else begin
                    m_block <= merged;
                    cnt     <= cnt + 4'd1;
                end
            end
            if (hs) begin
                if (pend_extra) begin
                    m_block    <= {BYTES_PER_BLOCK{PKCS_FULL_PAD}};
                    m_last     <= 1'b1;
                    pend_extra <= 1'b0;
                end else if (m_last) begin
                    busy  <= 1'b0;
                    first <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - randomized self-checking bench for aes_block_loader
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic [127:0] key;
    logic         m_ready;
    logic         sel;

    logic         s_ready_a, m_valid_a, m_last_a, busy_a;
    logic [127:0] m_block_a, m_key_a;
    logic         s_ready_b, m_valid_b, m_last_b, busy_b;
    logic [127:0] m_block_b, m_key_b;

    logic         s_ready, m_valid, m_last, busy;
    logic [127:0] m_block, m_key;

    always #5 clk = ~clk;

    aes_block_loader #(.PAD_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & ~sel),
        .s_last(s_last), .s_ready(s_ready_a), .key(key), .m_block(m_block_a),
        .m_key(m_key_a), .m_valid(m_valid_a), .m_last(m_last_a),
        .m_ready(m_ready), .busy(busy_a)
    );

    aes_block_loader #(.PAD_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid & sel),
        .s_last(s_last), .s_ready(s_ready_b), .key(key), .m_block(m_block_b),
        .m_key(m_key_b), .m_valid(m_valid_b), .m_last(m_last_b),
        .m_ready(m_ready), .busy(busy_b)
    );

    assign s_ready = sel ? s_ready_b : s_ready_a;
    assign m_valid = sel ? m_valid_b : m_valid_a;
    assign m_last  = sel ? m_last_b  : m_last_a;
    assign busy    = sel ? busy_b    : busy_a;
    assign m_block = sel ? m_block_b : m_block_a;
    assign m_key   = sel ? m_key_b   : m_key_a;

    typedef struct {
        logic [127:0] blk;
        logic         last;
    } exp_t;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    logic         busy_m = 1'b0;
    logic [127:0] got[$];
    int           got_cyc[$];
    logic [7:0]   msg[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: pad the whole message first, then cut it into 16-byte blocks
    task automatic build_expected(input logic [7:0] bytes[$], input bit pad_en, output exp_t q[$]);
        logic [7:0]   p[$];
        logic [127:0] blk;
        int           nblk;
        int           pad;
        p = bytes;
        if (pad_en) begin
            pad = 16 - (bytes.size() % 16);
            for (int i = 0; i < pad; i++) p.push_back(8'(pad));
        end else begin
            while (p.size() % 16 != 0) p.push_back(8'h00);
        end
        nblk = p.size() / 16;
        q.delete();
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = p[16*b+j];
            q.push_back('{blk: blk, last: (b == nblk - 1)});
        end
    endtask

    // mode 0: m_ready high, no gaps; 1: random ready and gaps; 2: stall first block 5 cycles
    task automatic run_msg(input logic [7:0] bytes[$], input int mode);
        exp_t         q[$];
        exp_t         e;
        int           n = bytes.size();
        int           bi = 0;
        int           stall = 0;
        int           limit = 3000;
        logic [127:0] key_m = '0;
        logic         hold_prev = 1'b0;
        logic [127:0] prev_blk = '0, prev_key = '0;
        logic         prev_last = 1'b0;
        build_expected(bytes, !sel, q);
        got.delete();
        got_cyc.delete();
        while ((bi < n || q.size() > 0) && limit > 0) begin
            limit--;
            s_valid = (bi < n) && (mode != 1 || $urandom_range(0, 99) >= 30);
            s_data  = s_valid ? bytes[bi] : 8'($urandom);
            s_last  = s_valid ? (bi == n - 1) : 1'($urandom);
            key     = {$urandom, $urandom, $urandom, $urandom};
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = (stall >= 5);
            endcase
            @(negedge clk);
            if (m_valid) check("s_ready_low_in_hold", s_ready, 1'b0);
            if (hold_prev) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_block", m_block, prev_blk);
                check("hold_key", m_key, prev_key);
                check("hold_last", m_last, prev_last);
            end
            check("busy", busy, busy_m);
            if (mode == 2 && m_valid && got.size() == 0 && !m_ready) stall++;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_block", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("block", m_block, e.blk);
                    check("last", m_last, e.last);
                    check("key", m_key, key_m);
                    if (e.last) busy_m = 1'b0;
                end
                got.push_back(m_block);
                got_cyc.push_back(cyc);
            end
            hold_prev = m_valid && !m_ready;
            prev_blk  = m_block;
            prev_key  = m_key;
            prev_last = m_last;
            if (s_valid && s_ready) begin
                if (bi == 0) begin
                    key_m  = key;
                    busy_m = 1'b1;
                end
                bi++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("msg_complete", (bi == n) && (q.size() == 0), 1'b1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        key = '0; m_ready = 1'b0;
        #3;
        check("rst_m_block", m_block, '0);
        check("rst_m_key", m_key, '0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", s_ready, 1'b1);

        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(i * 17));
        run_msg(msg, 0);
        check("fips_nblocks", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("fips_block0", got[0], 128'h00112233445566778899aabbccddeeff);
            check("fips_pad_block", got[1], 128'h10101010101010101010101010101010);
            check("fips_pad_next_cycle", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
        end

        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(msg, 0);
        if (got.size() == 1) check("abc_block", got[0], 128'h6162630d0d0d0d0d0d0d0d0d0d0d0d0d);
        @(negedge clk);
        check("abc_busy_fell", busy, 1'b0);
        @(posedge clk);
        #1;

        sel = 1'b1;
        msg.delete();
        msg.push_back(8'hAA);
        run_msg(msg, 0);
        check("nopad_nblocks", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("nopad_block", got[0], 128'hAA000000000000000000000000000000);
        sel = 1'b0;

        msg.delete();
        for (int i = 0; i < 20; i++) msg.push_back(8'(8'h30 + i));
        run_msg(msg, 2);
        if (got.size() == 2) check("stall_block1", got[1], 128'h404142430c0c0c0c0c0c0c0c0c0c0c0c);

        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = 8'(8'hE0 + i); s_last = 1'b0;
            key = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_m_block", m_block, '0);
        check("async_rst_m_key", m_key, '0);
        check("async_rst_m_valid", m_valid, 1'b0);
        check("async_rst_m_last", m_last, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        busy_m = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'(8'hA0 + i));
        run_msg(msg, 0);
        if (got.size() >= 1) check("post_rst_block", got[0], 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

        for (int m = 0; m < 25; m++) begin
            sel = ($urandom_range(0, 3) == 0);
            msg.delete();
            for (int i = 0, n = $urandom_range(1, 40); i < n; i++) msg.push_back(8'($urandom));
            run_msg(msg, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
